core_lsu: RTL and testbench

Load/store unit in the MEM stage. It is the initiator side of the data-memory interface that feeds the WB stage's sized load path.
- Turns a MEM-stage access into a request/grant/response bus transaction.
- Generates byte enables and lane-replicated store data.
- Returns load data right-shifted to bit 0, so WB only has to zero- or sign-extend it.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/core_pkg.sv | 14 +
 rtl/core_lsu_align.sv | 44 ++++
 rtl/core_lsu.sv | 137 +++++++++++++
 tb/tb_core_lsu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core load/store path: LSU states and access size codes.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/core_lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, misalignment, load shift.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module core_lsu_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      rd_off,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic            misaligned,
    output logic [XLEN-1:0] rdata_shift
);

    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << off;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = off[0];
            end
            default: begin
                // 2'b11 is treated as a word access
                misaligned = (off != 2'b00);
            end
        endcase
    end

    // Upper bits are passed through; WB masks or extends them
    assign rdata_shift = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/core_lsu.sv
// MEM-stage load/store unit driving a req/gnt/rvalid data-memory bus.
// Latency: 2 cycles for stores and same-cycle gnt+rvalid loads, 3+ otherwise.
// Backpressure: holds o_stall while a transaction waits on gnt or rvalid.
module core_lsu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mem_valid,
    input  logic            i_mem_write,
    input  logic [1:0]      i_d_size,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_done,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    lsu_state_e state, state_nxt;

    logic            we_q;
    logic [XLEN-3:0] addr_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      off_q;

    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic            misaligned_c;
    logic [XLEN-1:0] rdata_c;
    logic            start;

    core_lsu_align #(.XLEN(XLEN)) u_align (
        .size        (i_d_size),
        .off         (i_addr[1:0]),
        .wdata       (i_wdata),
        .rd_off      (off_q),
        .rdata       (i_dmem_rdata),
        .be          (be_c),
        .wdata_rep   (wdata_c),
        .misaligned  (misaligned_c),
        .rdata_shift (rdata_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            off_q   <= 2'b00;
        end else if (start) begin
            we_q    <= i_mem_write;
            addr_q  <= i_addr[XLEN-1:2];
            be_q    <= be_c;
            wdata_q <= wdata_c;
            off_q   <= i_addr[1:0];
        end
    end

    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        o_stall      = 1'b0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        o_rdata      = '0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_be    = 4'b0000;
        o_dmem_wdata = '0;
        case (state)
            IDLE: begin
                // The reset gate keeps every output low while i_rst is held
                if (i_mem_valid && !i_rst) begin
                    if (misaligned_c) begin
                        o_misaligned = 1'b1;
                    end else begin
                        start     = 1'b1;
                        o_stall   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = we_q;
                o_dmem_addr  = {addr_q, 2'b00};
                o_dmem_be    = be_q;
                o_dmem_wdata = wdata_q;
                if (i_dmem_gnt && (we_q || i_dmem_rvalid)) begin
                    o_done    = 1'b1;
                    o_rdata   = we_q ? '0 : rdata_c;
                    state_nxt = IDLE;
                end else if (i_dmem_gnt) begin
                    o_stall   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    o_stall = 1'b1;
                end
            end
            RESP: begin
                if (i_dmem_rvalid) begin
                    o_done    = 1'b1;
                    o_rdata   = rdata_c;
                    state_nxt = IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_lsu.sv
// Directed self-checking bench for core_lsu; the bus side is driven by hand per step.
module tb_core_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_mem_valid;
    logic        i_mem_write;
    logic [1:0]  i_d_size;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic        o_misaligned;
    logic [31:0] o_rdata;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    core_lsu #(.XLEN(32)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_mem_valid   (i_mem_valid),
        .i_mem_write   (i_mem_write),
        .i_d_size      (i_d_size),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_misaligned  (o_misaligned),
        .o_rdata       (o_rdata),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_be     (o_dmem_be),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk1({tag, ".req"}, o_dmem_req, 1'b0);
        chk1({tag, ".we"}, o_dmem_we, 1'b0);
        chk32({tag, ".addr"}, o_dmem_addr, 32'h0);
        chk32({tag, ".be"}, {28'h0, o_dmem_be}, 32'h0);
        chk32({tag, ".wdata"}, o_dmem_wdata, 32'h0);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic access(input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        i_mem_valid = 1'b1;
        i_mem_write = wr;
        i_d_size    = sz;
        i_addr      = a;
        i_wdata     = d;
    endtask

    initial begin
        // Reset with a misaligned access presented: every output must stay low
        i_rst = 1'b1;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        access(1'b0, 2'b10, 32'h0000_4001, 32'hFFFF_FFFF);
        @(negedge i_clk);
        chk1("rst.stall", o_stall, 1'b0);
        chk1("rst.done", o_done, 1'b0);
        chk1("rst.misaligned", o_misaligned, 1'b0);
        chk32("rst.rdata", o_rdata, 32'h0);
        chk_idle_bus("rst");
        step();
        i_mem_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk1("idle.stall", o_stall, 1'b0);
        chk1("idle.req", o_dmem_req, 1'b0);

        // Store byte at 0x1003, zero-wait grant
        step();
        access(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB);
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        chk1("sb.c1.stall", o_stall, 1'b1);
        chk1("sb.c1.done", o_done, 1'b0);
        chk1("sb.c1.req", o_dmem_req, 1'b0);
        step();
        @(negedge i_clk);
        chk1("sb.c2.req", o_dmem_req, 1'b1);
        chk1("sb.c2.we", o_dmem_we, 1'b1);
        chk32("sb.c2.be", {28'h0, o_dmem_be}, 32'h8);
        chk32("sb.c2.wdata", o_dmem_wdata, 32'hABAB_ABAB);
        chk32("sb.c2.addr", o_dmem_addr, 32'h0000_1000);
        chk1("sb.c2.done", o_done, 1'b1);
        chk1("sb.c2.stall", o_stall, 1'b0);
        step();
        i_mem_valid = 1'b0;

        // Load half at 0x2002, response one cycle after grant
        access(1'b0, 2'b01, 32'h0000_2002, 32'h0);
        @(negedge i_clk);
        chk1("lh.c1.stall", o_stall, 1'b1);
        step();
        @(negedge i_clk);
        chk1("lh.c2.req", o_dmem_req, 1'b1);
        chk1("lh.c2.we", o_dmem_we, 1'b0);
        chk32("lh.c2.be", {28'h0, o_dmem_be}, 32'hC);
        chk32("lh.c2.addr", o_dmem_addr, 32'h0000_2000);
        chk1("lh.c2.stall", o_stall, 1'b1);
        chk1("lh.c2.done", o_done, 1'b0);
        step();
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'hBEEF_1234;
        @(negedge i_clk);
        chk1("lh.c3.req", o_dmem_req, 1'b0);
        chk1("lh.c3.done", o_done, 1'b1);
        chk1("lh.c3.stall", o_stall, 1'b0);
        chk32("lh.c3.rdata", o_rdata, 32'h0000_BEEF);
        step();
        i_mem_valid = 1'b0;
        i_dmem_rvalid = 1'b0;

        // Word store at 0x3000 with grant held off for three REQ cycles
        access(1'b1, 2'b10, 32'h0000_3000, 32'hCAFE_F00D);
        @(negedge i_clk);
        chk1("sw.c1.stall", o_stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge i_clk);
            chk1("sw.wait.req", o_dmem_req, 1'b1);
            chk32("sw.wait.addr", o_dmem_addr, 32'h0000_3000);
            chk32("sw.wait.wdata", o_dmem_wdata, 32'hCAFE_F00D);
            chk32("sw.wait.be", {28'h0, o_dmem_be}, 32'hF);
            chk1("sw.wait.stall", o_stall, 1'b1);
            chk1("sw.wait.done", o_done, 1'b0);
        end
        step();
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        chk1("sw.gnt.done", o_done, 1'b1);
        chk1("sw.gnt.stall", o_stall, 1'b0);
        chk1("sw.gnt.req", o_dmem_req, 1'b1);
        step();
        i_mem_valid = 1'b0;
        @(negedge i_clk);
        chk1("sw.after.done", o_done, 1'b0);
        chk1("sw.after.req", o_dmem_req, 1'b0);

        // Misaligned word then misaligned half: no bus activity, no stall
        step();
        access(1'b0, 2'b10, 32'h0000_4001, 32'h0);
        @(negedge i_clk);
        chk1("mis.w.flag", o_misaligned, 1'b1);
        chk1("mis.w.stall", o_stall, 1'b0);
        chk1("mis.w.done", o_done, 1'b0);
        chk_idle_bus("mis.w");
        step();
        access(1'b1, 2'b01, 32'h0000_4003, 32'h1234_5678);
        @(negedge i_clk);
        chk1("mis.h.flag", o_misaligned, 1'b1);
        chk1("mis.h.stall", o_stall, 1'b0);
        chk_idle_bus("mis.h");
        step();
        @(negedge i_clk);
        chk1("mis.h2.req", o_dmem_req, 1'b0);
        step();
        i_mem_valid = 1'b0;
        @(negedge i_clk);
        chk1("mis.clear", o_misaligned, 1'b0);

        // Reset asserted between edges while waiting in RESP
        step();
        access(1'b0, 2'b10, 32'h0000_5000, 32'h0);
        i_dmem_gnt = 1'b1;
        step();
        step();
        i_dmem_gnt = 1'b0;
        @(negedge i_clk);
        chk1("rr.resp.stall", o_stall, 1'b1);
        chk1("rr.resp.req", o_dmem_req, 1'b0);
        #1;
        i_rst = 1'b1;
        #1;
        chk1("rr.async.stall", o_stall, 1'b0);
        chk1("rr.async.done", o_done, 1'b0);
        chk1("rr.async.mis", o_misaligned, 1'b0);
        chk32("rr.async.rdata", o_rdata, 32'h0);
        chk_idle_bus("rr.async");
        step();
        i_mem_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk1("rr.idle.stall", o_stall, 1'b0);
        chk1("rr.idle.req", o_dmem_req, 1'b0);
        step();
        access(1'b0, 2'b10, 32'h0000_5004, 32'h0);
        i_dmem_gnt = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'h1234_5678;
        @(negedge i_clk);
        chk1("rr.ld.c1.stall", o_stall, 1'b1);
        step();
        @(negedge i_clk);
        chk32("rr.ld.addr", o_dmem_addr, 32'h0000_5004);
        chk1("rr.ld.done", o_done, 1'b1);
        chk32("rr.ld.rdata", o_rdata, 32'h1234_5678);

        // Back-to-back: load word 0x10, then store half 0x14, same-cycle gnt+rvalid
        step();
        access(1'b0, 2'b10, 32'h0000_0010, 32'h0);
        i_dmem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        chk1("bb.c1.stall", o_stall, 1'b1);
        chk1("bb.c1.done", o_done, 1'b0);
        step();
        @(negedge i_clk);
        chk1("bb.c2.done", o_done, 1'b1);
        chk32("bb.c2.be", {28'h0, o_dmem_be}, 32'hF);
        chk32("bb.c2.addr", o_dmem_addr, 32'h0000_0010);
        chk32("bb.c2.rdata", o_rdata, 32'hDEAD_BEEF);
        step();
        access(1'b1, 2'b01, 32'h0000_0014, 32'h5555_AAAA);
        @(negedge i_clk);
        chk1("bb.c3.done", o_done, 1'b0);
        chk1("bb.c3.stall", o_stall, 1'b1);
        step();
        @(negedge i_clk);
        chk1("bb.c4.done", o_done, 1'b1);
        chk1("bb.c4.we", o_dmem_we, 1'b1);
        chk32("bb.c4.be", {28'h0, o_dmem_be}, 32'h3);
        chk32("bb.c4.wdata", o_dmem_wdata, 32'hAAAA_AAAA);
        chk32("bb.c4.addr", o_dmem_addr, 32'h0000_0014);
        step();
        i_mem_valid = 1'b0;
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
        @(negedge i_clk);
        chk1("bb.end.stall", o_stall, 1'b0);
        chk1("bb.end.req", o_dmem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
